tug_war_engine: RTL and testbench
=================================

# tug_war_engine

Parametrised tug-of-war game core: a single lit marker on a bar of NUM_LIGHTS lights moves one step per pull, and each side scores a point by pulling the marker off its own end. It adds configurable bar length, a scored match to WIN_SCORE with a match-over lock, a post-point hold display, and an LFSR computer opponent with a programmable difficulty. It sits between the board pushbuttons/switches and the LED bar and seven-segment score decoders in the game top level.

## Interface
- NUM_LIGHTS, 9, bar length; odd, 3..31
- SCORE_W, 3, score counter width
- WIN_SCORE, 7, points to win a match; 1..2^SCORE_W-1
- HOLD_CYCLES, 4, cycles the point light is held before re-centre; >=1
- LFSR_W, 10, CPU LFSR width; one of 8..12
- Clock  in  1  single system clock; all state changes on posedge
- Reset  in  1  asynchronous, active-high; clears all state
- left_raw  in  1  left player button level, active-high, synchronous to Clock
- right_raw  in  1  right player button level, active-high, synchronous to Clock
- cpu_en  in  1  1 = CPU also pulls for the left side
- cpu_level  in  LFSR_W  CPU difficulty; larger = more frequent pulls
- new_match  in  1  level, sampled each cycle; starts a fresh match
- lights  out  NUM_LIGHTS  one-hot marker; bit 0 = right end
- score_l  out  SCORE_W  left score
- score_r  out  SCORE_W  right score
- match_over  out  1  high while a match is decided
- winner  out  1  valid when match_over: 1 = left, 0 = right

## Operation
- Marker position pos is 0..NUM_LIGHTS-1; centre C = (NUM_LIGHTS-1)/2. lights = 1<<pos in PLAY and POINT states.
- Edge detect: left_q/right_q register the raw inputs each cycle. press_l = left_raw & ~left_q; press_r = right_raw & ~right_q. A held button produces exactly one press.
- CPU: Fibonacci LFSR advances every cycle when cpu_en = 1. It is seeded with 1 on Reset and never reaches 0. Taps: 8: 8,6,5,4; 9: 9,5; 10: 10,7; 11: 11,9; 12: 12,6,4,1.
  - cpu_pull = cpu_en & carry-out of the (LFSR_W+1)-bit sum lfsr + cpu_level.
  - cpu_level = 0 never pulls; cpu_level = all ones pulls every cycle.
- pull_l = press_l | cpu_pull; pull_r = press_r.
- State machine, three states:
  - PLAY:
    - pull_l & pull_r: cancel, no move.
    - pull_l only: if pos = NUM_LIGHTS-1, left scores and the FSM goes to POINT; else pos+1.
    - pull_r only: if pos = 0, right scores and the FSM goes to POINT; else pos-1.
  - POINT: marker held at the scoring end. A hold counter runs HOLD_CYCLES cycles and pulls are ignored.
    - If the scorer's new score = WIN_SCORE, go to OVER.
    - Otherwise pos = C and go to PLAY.
  - OVER: lights = 0, match_over = 1, winner is held, pulls are ignored.
- Scores increment by 1 and never exceed WIN_SCORE.
- new_match = 1 in any state: scores = 0, pos = C, hold counter cleared, state PLAY, match_over = 0. It has priority over all pulls that cycle. The LFSR is not reset.
- Reset values: pos = C (lights = 1<<C), score_l = score_r = 0, match_over = 0, winner = 0, state PLAY, left_q = right_q = 0, LFSR = 1.

## Timing
- Pull latency: the first posedge at which left_raw = 1 (after a 0) updates pos at that same edge, so lights reflect it in the following cycle.
- Scoring pull at an end: the score increments and POINT is entered on the same edge.
- POINT lasts exactly HOLD_CYCLES cycles. The edge ending it sets pos = C and PLAY, or enters OVER. match_over rises on that edge.
- A press whose rising edge occurs during POINT or OVER is consumed and lost. A button held across the return to PLAY does not pull.
- Async Reset mid-POINT or mid-OVER returns to the reset values immediately, with no clock needed.

## Test plan
- Reset, NUM_LIGHTS = 9: lights = 9'b000010000 and both scores are 0. Deassert Reset, then hold right_raw high for 3 cycles → pos moves exactly once, to 3.
- From pos = 0, pulse right_raw → score_r = 1, lights stay 9'b000000001 for 4 cycles, then return to 9'b000010000.
- In PLAY with cpu_en = 1 and cpu_level = all ones, raise right_raw once → both sides pull in the same cycle, pos unchanged. Then drop right_raw → pos increments once per cycle until left scores.
- cpu_en = 1, cpu_level = 0, no buttons, 1000 cycles → lights unchanged.
- Drive 7 right points → match_over = 1, winner = 0, score_r = 7, lights = 0. Further presses do nothing. new_match → scores 0, lights = 9'b000010000.
- Assert Reset during POINT mid-hold → all outputs take reset values before the next edge. Regress with NUM_LIGHTS = 3 and 15, and WIN_SCORE = 1.

Source files
------------

// File: rtl/tug_war_engine.sv
// tug_war_engine: tug-of-war game core.
// A one-hot marker walks along a bar of NUM_LIGHTS lights. Each pull moves it
// one step, and pulling it off your own end scores a point. After a point the
// marker is held at the scoring end for HOLD_CYCLES cycles. The first side to
// reach WIN_SCORE locks the match until new_match_i is asserted. An LFSR-based
// computer opponent can also pull for the left side.
module tug_war_engine #(
    parameter int NUM_LIGHTS  = 9,
    parameter int SCORE_W     = 3,
    parameter int WIN_SCORE   = 7,
    parameter int HOLD_CYCLES = 4,
    parameter int LFSR_W      = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  left_raw_i,
    input  logic                  right_raw_i,
    input  logic                  cpu_en_i,
    input  logic [LFSR_W-1:0]     cpu_level_i,
    input  logic                  new_match_i,
    output logic [NUM_LIGHTS-1:0] lights_o,
    output logic [SCORE_W-1:0]    score_l_o,
    output logic [SCORE_W-1:0]    score_r_o,
    output logic                  match_over_o,
    output logic                  winner_o
);

    localparam int POS_W  = $clog2(NUM_LIGHTS);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [POS_W-1:0]   POS_C     = POS_W'((NUM_LIGHTS - 1) / 2);
    localparam logic [POS_W-1:0]   POS_MAX   = POS_W'(NUM_LIGHTS - 1);
    localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    // Fibonacci feedback tap masks (bit n-1 set for tap n), one per width.
    localparam logic [11:0] TAPS_ALL =
        (LFSR_W == 8)  ? 12'h0B8 :
        (LFSR_W == 9)  ? 12'h110 :
        (LFSR_W == 10) ? 12'h240 :
        (LFSR_W == 11) ? 12'h500 :
                         12'h829;
    localparam logic [LFSR_W-1:0] TAPS = TAPS_ALL[LFSR_W-1:0];

    localparam logic [1:0] ST_PLAY  = 2'd0;
    localparam logic [1:0] ST_POINT = 2'd1;
    localparam logic [1:0] ST_OVER  = 2'd2;

    logic [1:0]         state_q,   state_d;
    logic [POS_W-1:0]   pos_q,     pos_d;
    logic [SCORE_W-1:0] score_l_q, score_l_d;
    logic [SCORE_W-1:0] score_r_q, score_r_d;
    logic [HOLD_W-1:0]  hold_q,    hold_d;
    logic               scorer_q,  scorer_d;   // 1 = left scored the last point
    logic               winner_q,  winner_d;
    logic [LFSR_W-1:0]  lfsr_q,    lfsr_d;
    logic               left_q,    right_q;

    logic press_l, press_r, cpu_pull, pull_l, pull_r, lfsr_fb;

    // Rising-edge detection so a held button only pulls once.
    assign press_l = left_raw_i  & ~left_q;
    assign press_r = right_raw_i & ~right_q;

    // lfsr + level carries out of LFSR_W bits exactly when lfsr > ~level.
    // Level 0 never pulls; all-ones always pulls since the LFSR is never 0.
    assign cpu_pull = cpu_en_i & (lfsr_q > ~cpu_level_i);
    assign pull_l   = press_l | cpu_pull;
    assign pull_r   = press_r;

    // LFSR next value: shift left, feedback is the XOR of the tap bits.
    assign lfsr_fb = ^(lfsr_q & TAPS);
    always_comb begin
        lfsr_d = lfsr_q;
        if (cpu_en_i) begin
            lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_fb};
        end
    end

    // Game state machine: marker movement, scoring, point hold and match lock.
    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        hold_d    = hold_q;
        scorer_d  = scorer_q;
        winner_d  = winner_q;
        if (new_match_i) begin
            state_d   = ST_PLAY;
            pos_d     = POS_C;
            score_l_d = '0;
            score_r_d = '0;
            hold_d    = '0;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (pull_l && !pull_r) begin
                        if (pos_q == POS_MAX) begin
                            if (score_l_q != WIN) begin
                                score_l_d = score_l_q + 1'b1;
                            end
                            scorer_d = 1'b1;
                            hold_d   = '0;
                            state_d  = ST_POINT;
                        end else begin
                            pos_d = pos_q + 1'b1;
                        end
                    end else if (pull_r && !pull_l) begin
                        if (pos_q == '0) begin
                            if (score_r_q != WIN) begin
                                score_r_d = score_r_q + 1'b1;
                            end
                            scorer_d = 1'b0;
                            hold_d   = '0;
                            state_d  = ST_POINT;
                        end else begin
                            pos_d = pos_q - 1'b1;
                        end
                    end
                end
                ST_POINT: begin
                    // Scores were already bumped on entry, so compare directly.
                    if (hold_q == HOLD_LAST) begin
                        hold_d = '0;
                        if ((scorer_q ? score_l_q : score_r_q) == WIN) begin
                            winner_d = scorer_q;
                            state_d  = ST_OVER;
                        end else begin
                            pos_d   = POS_C;
                            state_d = ST_PLAY;
                        end
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                ST_OVER: begin
                    state_d = ST_OVER;
                end
                default: begin
                    state_d = ST_PLAY;
                    pos_d   = POS_C;
                end
            endcase
        end
    end

    // State registers, cleared asynchronously by rst_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_PLAY;
            pos_q     <= POS_C;
            score_l_q <= '0;
            score_r_q <= '0;
            hold_q    <= '0;
            scorer_q  <= 1'b0;
            winner_q  <= 1'b0;
            lfsr_q    <= LFSR_W'(1);
            left_q    <= 1'b0;
            right_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            hold_q    <= hold_d;
            scorer_q  <= scorer_d;
            winner_q  <= winner_d;
            lfsr_q    <= lfsr_d;
            left_q    <= left_raw_i;
            right_q   <= right_raw_i;
        end
    end

    // One-hot bar decode; dark once the match is decided.
    for (genvar gi = 0; gi < NUM_LIGHTS; gi++) begin : g_lights
        assign lights_o[gi] = (state_q != ST_OVER) && (pos_q == POS_W'(gi));
    end

    assign score_l_o    = score_l_q;
    assign score_r_o    = score_r_q;
    assign match_over_o = (state_q == ST_OVER);
    assign winner_o     = winner_q;

endmodule

// File: tb/tb_tug_war_engine.sv
// Testbench for tug_war_engine: two instances (9-light/first-to-7 and
// 3-light/first-to-1), table-driven vectors fed through a scoreboard queue.
module tb_tug_war_engine;

    typedef struct {
        bit          sel;     // 0 = dut_a, 1 = dut_b
        bit          l;
        bit          r;
        bit          ce;
        logic [9:0]  lvl;
        bit          nm;
        logic [14:0] lights;
        int          sl;
        int          sr;
        bit          over;
        bit          win;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       a_l = 0, a_r = 0, a_ce = 0, a_nm = 0;
    logic [9:0] a_lvl = '0;
    logic [8:0] a_lights;
    logic [2:0] a_sl, a_sr;
    logic       a_over, a_win;

    logic       b_l = 0, b_r = 0, b_ce = 0, b_nm = 0;
    logic [7:0] b_lvl = '0;
    logic [2:0] b_lights;
    logic [2:0] b_sl, b_sr;
    logic       b_over, b_win;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_no  = 0;
    vec_t exp_q[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    tug_war_engine #(
        .NUM_LIGHTS(9), .SCORE_W(3), .WIN_SCORE(7), .HOLD_CYCLES(4), .LFSR_W(10)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .left_raw_i(a_l), .right_raw_i(a_r),
        .cpu_en_i(a_ce), .cpu_level_i(a_lvl), .new_match_i(a_nm),
        .lights_o(a_lights), .score_l_o(a_sl), .score_r_o(a_sr),
        .match_over_o(a_over), .winner_o(a_win)
    );

    tug_war_engine #(
        .NUM_LIGHTS(3), .SCORE_W(3), .WIN_SCORE(1), .HOLD_CYCLES(2), .LFSR_W(8)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .left_raw_i(b_l), .right_raw_i(b_r),
        .cpu_en_i(b_ce), .cpu_level_i(b_lvl), .new_match_i(b_nm),
        .lights_o(b_lights), .score_l_o(b_sl), .score_r_o(b_sr),
        .match_over_o(b_over), .winner_o(b_win)
    );

    function automatic vec_t mk(bit sel, bit l, bit r, bit ce, logic [9:0] lvl, bit nm,
                                logic [14:0] lights, int sl, int sr, bit over, bit win);
        vec_t v;
        v.sel = sel; v.l = l; v.r = r; v.ce = ce; v.lvl = lvl; v.nm = nm;
        v.lights = lights; v.sl = sl; v.sr = sr; v.over = over; v.win = win;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %0h, expected %0h", name, step_no, act, exp);
        end
    endtask

    // Pop the oldest expectation and compare it with the selected DUT.
    task automatic compare_out();
        vec_t        e;
        logic [14:0] lt;
        logic [31:0] sl, sr, ov, wn;
        e = exp_q.pop_front();
        if (e.sel == 1'b0) begin
            lt = {6'b0, a_lights}; sl = 32'(a_sl); sr = 32'(a_sr); ov = 32'(a_over); wn = 32'(a_win);
        end else begin
            lt = {12'b0, b_lights}; sl = 32'(b_sl); sr = 32'(b_sr); ov = 32'(b_over); wn = 32'(b_win);
        end
        $display("step %0d dut%0d l=%0b r=%0b ce=%0b nm=%0b lights=%h score_l=%0d score_r=%0d over=%0b",
                 step_no, e.sel, e.l, e.r, e.ce, e.nm, lt, sl, sr, ov);
        chk("lights", 32'(lt), 32'(e.lights));
        chk("score_l", sl, 32'(e.sl));
        chk("score_r", sr, 32'(e.sr));
        chk("match_over", ov, 32'(e.over));
        if (e.over) chk("winner", wn, 32'(e.win));
    endtask

    // Drive one cycle of inputs, queue the expectation, compare after the edge.
    task automatic apply(vec_t v);
        if (v.sel == 1'b0) begin
            a_l = v.l; a_r = v.r; a_ce = v.ce; a_lvl = v.lvl; a_nm = v.nm;
            b_l = 0; b_r = 0; b_ce = 0; b_lvl = '0; b_nm = 0;
        end else begin
            b_l = v.l; b_r = v.r; b_ce = v.ce; b_lvl = v.lvl[7:0]; b_nm = v.nm;
            a_l = 0; a_r = 0; a_ce = 0; a_lvl = '0; a_nm = 0;
        end
        exp_q.push_back(v);
        step_no++;
        @(posedge clk);
        @(negedge clk);
        compare_out();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [14:0] one;
        one = 15'd1;

        // Directed A vectors: right walk, right point + hold, held buttons,
        // cancel, CPU all-ones pulls and a left point.
        tbl.push_back(mk(0,0,1,0,10'h000,0,15'h008,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,10'h000,0,15'h008,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,10'h000,0,15'h008,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,10'h000,0,15'h008,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,10'h000,0,15'h004,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,10'h000,0,15'h004,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,10'h000,0,15'h002,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,10'h000,0,15'h002,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,10'h000,0,15'h001,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,10'h000,0,15'h001,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,10'h000,0,15'h001,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,10'h000,0,15'h001,0,1,0,0));
        tbl.push_back(mk(0,1,0,0,10'h000,0,15'h001,0,1,0,0));
        tbl.push_back(mk(0,1,0,0,10'h000,0,15'h001,0,1,0,0));
        tbl.push_back(mk(0,1,0,0,10'h000,0,15'h010,0,1,0,0));
        tbl.push_back(mk(0,1,0,0,10'h000,0,15'h010,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,10'h000,0,15'h010,0,1,0,0));
        tbl.push_back(mk(0,1,0,0,10'h000,0,15'h020,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,10'h000,0,15'h020,0,1,0,0));
        tbl.push_back(mk(0,1,1,0,10'h000,0,15'h020,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,10'h000,0,15'h020,0,1,0,0));
        tbl.push_back(mk(0,0,1,1,10'h3FF,0,15'h020,0,1,0,0));
        tbl.push_back(mk(0,0,0,1,10'h3FF,0,15'h040,0,1,0,0));
        tbl.push_back(mk(0,0,0,1,10'h3FF,0,15'h080,0,1,0,0));
        tbl.push_back(mk(0,0,0,1,10'h3FF,0,15'h100,0,1,0,0));
        tbl.push_back(mk(0,0,0,1,10'h3FF,0,15'h100,1,1,0,0));
        tbl.push_back(mk(0,0,0,1,10'h3FF,0,15'h100,1,1,0,0));
        tbl.push_back(mk(0,0,0,1,10'h3FF,0,15'h100,1,1,0,0));
        tbl.push_back(mk(0,0,0,0,10'h000,0,15'h100,1,1,0,0));
        tbl.push_back(mk(0,0,0,0,10'h000,0,15'h010,1,1,0,0));

        // Reset state, checked while reset is still asserted.
        @(negedge clk);
        @(negedge clk);
        chk("reset_lights_a", 32'(a_lights), 32'h010);
        chk("reset_score_l_a", 32'(a_sl), 0);
        chk("reset_score_r_a", 32'(a_sr), 0);
        chk("reset_over_a", 32'(a_over), 0);
        chk("reset_winner_a", 32'(a_win), 0);
        chk("reset_lights_b", 32'(b_lights), 32'h2);
        rst = 1'b0;

        foreach (tbl[i]) apply(tbl[i]);

        // CPU enabled at level 0 never pulls.
        for (int i = 0; i < 1000; i++) apply(mk(0,0,0,1,10'h000,0,15'h010,1,1,0,0));

        // Right wins points 2..7; the last one ends the match.
        for (int pt = 2; pt <= 7; pt++) begin
            for (int i = 0; i < 4; i++) begin
                apply(mk(0,0,1,0,10'h000,0,one << (3 - i),1,pt-1,0,0));
                apply(mk(0,0,0,0,10'h000,0,one << (3 - i),1,pt-1,0,0));
            end
            apply(mk(0,0,1,0,10'h000,0,15'h001,1,pt,0,0));
            for (int i = 0; i < 3; i++) apply(mk(0,0,0,0,10'h000,0,15'h001,1,pt,0,0));
            if (pt == 7) apply(mk(0,0,0,0,10'h000,0,15'h000,1,7,1,0));
            else         apply(mk(0,0,0,0,10'h000,0,15'h010,1,pt,0,0));
        end

        // Match locked: presses ignored. new_match wins over a same-cycle press.
        apply(mk(0,0,1,0,10'h000,0,15'h000,1,7,1,0));
        apply(mk(0,1,0,0,10'h000,0,15'h000,1,7,1,0));
        apply(mk(0,0,1,0,10'h000,1,15'h010,0,0,0,0));
        apply(mk(0,0,1,0,10'h000,0,15'h010,0,0,0,0));
        apply(mk(0,0,0,0,10'h000,0,15'h010,0,0,0,0));

        // Small bar, first to 1, hold of 2: left wins the match.
        apply(mk(1,1,0,0,10'h000,0,15'h4,0,0,0,0));
        apply(mk(1,0,0,0,10'h000,0,15'h4,0,0,0,0));
        apply(mk(1,1,0,0,10'h000,0,15'h4,1,0,0,0));
        apply(mk(1,0,0,0,10'h000,0,15'h4,1,0,0,0));
        apply(mk(1,0,0,0,10'h000,0,15'h0,1,0,1,1));
        apply(mk(1,1,0,0,10'h000,0,15'h0,1,0,1,1));
        apply(mk(1,0,0,0,10'h000,1,15'h2,0,0,0,0));

        // Reset in the middle of a point hold on dut_a.
        for (int i = 0; i < 4; i++) begin
            apply(mk(0,0,1,0,10'h000,0,one << (3 - i),0,0,0,0));
            apply(mk(0,0,0,0,10'h000,0,one << (3 - i),0,0,0,0));
        end
        apply(mk(0,0,1,0,10'h000,0,15'h001,0,1,0,0));
        apply(mk(0,0,0,0,10'h000,0,15'h001,0,1,0,0));
        rst = 1'b1;
        #1;
        chk("async_rst_lights", 32'(a_lights), 32'h010);
        chk("async_rst_score_r", 32'(a_sr), 0);
        chk("async_rst_score_l", 32'(a_sl), 0);
        chk("async_rst_over", 32'(a_over), 0);
        chk("async_rst_winner", 32'(a_win), 0);
        @(negedge clk);
        rst = 1'b0;
        apply(mk(0,0,0,0,10'h000,0,15'h010,0,0,0,0));
        apply(mk(0,0,1,0,10'h000,0,15'h008,0,0,0,0));

        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
